// File: rtl/sram_arbiter_if.sv
// Bus bundle between the two pipeline requesters, the arbiter and the unified SRAM.
// The slave modport is the arbiter's view; master is the requesters plus RAM side.
interface sram_arbiter_if;
    logic        inst_req;
    logic        inst_wr;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport slave (
        input  inst_req, inst_wr, inst_wstrb, inst_addr, inst_wdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata,
        input  sram_rdata
    );

    modport master (
        output inst_req, inst_wr, inst_wstrb, inst_addr, inst_wdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-requester arbiter for one single-port synchronous SRAM: data port has priority,
// instruction port is forced through after STARVE_LIMIT consecutive denials.
module sram_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic clk,
    input  logic reset,
    sram_arbiter_if.slave bus
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic             force_inst;
    logic             gnt_data;
    logic             gnt_inst;
    logic             resp_valid_d, resp_valid_q;
    logic             resp_owner_d, resp_owner_q;
    logic [CNT_W-1:0] starve_cnt_d, starve_cnt_q;

    // Grants are blanked while reset is held so nothing reaches the RAM.
    always_comb begin
        force_inst = bus.inst_req && (starve_cnt_q == LIMIT);
        gnt_data   = !reset && bus.data_req && !force_inst;
        gnt_inst   = !reset && bus.inst_req && !gnt_data;
    end

    always_comb begin
        bus.sram_en    = gnt_inst | gnt_data;
        bus.sram_we    = 4'b0;
        bus.sram_addr  = 32'b0;
        bus.sram_wdata = 32'b0;
        if (gnt_data) begin
            bus.sram_we    = bus.data_wr ? bus.data_wstrb : 4'b0;
            bus.sram_addr  = bus.data_addr;
            bus.sram_wdata = bus.data_wdata;
        end else if (gnt_inst) begin
            bus.sram_we    = bus.inst_wr ? bus.inst_wstrb : 4'b0;
            bus.sram_addr  = bus.inst_addr;
            bus.sram_wdata = bus.inst_wdata;
        end
    end

    always_comb begin
        resp_valid_d = gnt_inst | gnt_data;
        resp_owner_d = gnt_data;
        starve_cnt_d = starve_cnt_q;
        if (gnt_inst || !bus.inst_req) begin
            starve_cnt_d = '0;
        end else if (gnt_data && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Grant -> response stage: one cycle later the RAM word belongs to resp_owner_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_owner_q <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_owner_q <= resp_owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        bus.inst_addr_ok = gnt_inst;
        bus.data_addr_ok = gnt_data;
        bus.inst_data_ok = resp_valid_q && !resp_owner_q;
        bus.data_data_ok = resp_valid_q && resp_owner_q;
        bus.inst_rdata   = bus.sram_rdata;
        bus.data_rdata   = bus.sram_rdata;
    end
endmodule
